// File: rtl/jtag_pkg.sv
// jtag_pkg: command opcodes, IEEE 1149.1 TAP state encoding and next-state function
package jtag_pkg;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IDLE  = 2'd1;
    localparam logic [1:0] OP_IR    = 2'd2;
    localparam logic [1:0] OP_DR    = 2'd3;

    typedef enum logic [3:0] {
        EXIT2_DR = 4'h0,
        EXIT1_DR = 4'h1,
        SHIFT_DR = 4'h2,
        PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4,
        UPD_DR   = 4'h5,
        CAP_DR   = 4'h6,
        SEL_DR   = 4'h7,
        EXIT2_IR = 4'h8,
        EXIT1_IR = 4'h9,
        SHIFT_IR = 4'hA,
        PAUSE_IR = 4'hB,
        RTI      = 4'hC,
        UPD_IR   = 4'hD,
        CAP_IR   = 4'hE,
        TLR      = 4'hF
    } tap_state_e;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        case (s)
            TLR:      tap_next = tms ? TLR      : RTI;
            RTI:      tap_next = tms ? SEL_DR   : RTI;
            SEL_DR:   tap_next = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   tap_next = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: tap_next = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: tap_next = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: tap_next = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: tap_next = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   tap_next = tms ? SEL_DR   : RTI;
            SEL_IR:   tap_next = tms ? TLR      : CAP_IR;
            CAP_IR:   tap_next = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: tap_next = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: tap_next = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: tap_next = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: tap_next = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   tap_next = tms ? SEL_DR   : RTI;
        endcase
    endfunction

endpackage

// File: rtl/tap_state_tracker.sv
// tap_state_tracker: follows the target TAP position, advancing on each qualified TCK
module tap_state_tracker
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       TRST,
    input  logic       tck_en,
    input  logic       tms,
    output logic [3:0] state
);

    tap_state_e s;

    assign state = s;

    always_ff @(posedge clk or posedge TRST)
        if (TRST) s <= TLR;
        else if (tck_en) s <= tap_next(s, tms);

endmodule

// File: rtl/tap_scan_sequencer.sv
// tap_scan_sequencer: turns RESET/IDLE/SCAN commands into registered TMS/TDI/TCK-enable
// streams and returns the TDO bits captured while the target sits in Shift-IR/DR.
module tap_scan_sequencer
    import jtag_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               clk,
    input  logic               TRST,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_tdi,
    output logic               tms,
    output logic               tdi,
    output logic               tck_en,
    input  logic               tdo,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [MAX_LEN-1:0] rsp_tdo,
    output logic [3:0]         tap_obs
);

    localparam logic [2:0] READY    = 3'd0;
    localparam logic [2:0] PRE      = 3'd1;
    localparam logic [2:0] NAV_IN   = 3'd2;
    localparam logic [2:0] SHIFT    = 3'd3;
    localparam logic [2:0] NAV_OUT  = 3'd4;
    localparam logic [2:0] IDLE_RUN = 3'd5;
    localparam logic [2:0] RST_SEQ  = 3'd6;
    localparam logic [2:0] RESP     = 3'd7;

    logic [2:0]         st, nxt_st;
    logic [LEN_W-1:0]   cnt, nxt_cnt, last;
    logic [1:0]         op;
    logic               zero, accept, bad, pre_req, issue, nxt_tms;
    logic [MAX_LEN-1:0] dat;

    tap_state_tracker u_tracker (
        .clk    (clk),
        .TRST   (TRST),
        .tck_en (tck_en),
        .tms    (tms),
        .state  (tap_obs)
    );

    assign cmd_ready = st == READY;
    assign accept    = cmd_valid && cmd_ready;
    assign bad       = cmd_len == '0 || cmd_len > LEN_W'(MAX_LEN);
    assign pre_req   = tap_obs == TLR;

    // st/cnt name the bit that will be on the wire in the next cycle, so outputs register straight from them
    always_comb begin
        nxt_st  = st;
        nxt_cnt = cnt + LEN_W'(1);
        case (st)
            READY: begin
                nxt_cnt = '0;
                if (cmd_valid)
                    nxt_st = cmd_op == OP_RESET ? RST_SEQ :
                             cmd_op == OP_IDLE  ? (pre_req ? PRE : cmd_len == '0 ? RESP : IDLE_RUN) :
                             bad ? RESP : pre_req ? PRE : NAV_IN;
            end
            PRE: begin
                nxt_cnt = '0;
                nxt_st  = op != OP_IDLE ? NAV_IN : zero ? RESP : IDLE_RUN;
            end
            NAV_IN:   if (cnt == (op == OP_IR ? LEN_W'(3) : LEN_W'(2))) begin nxt_st = SHIFT; nxt_cnt = '0; end
            SHIFT:    if (cnt == last) begin nxt_st = NAV_OUT; nxt_cnt = '0; end
            NAV_OUT:  if (cnt == LEN_W'(1)) nxt_st = RESP;
            IDLE_RUN: if (cnt == last) nxt_st = RESP;
            RST_SEQ:  if (cnt == LEN_W'(4)) nxt_st = RESP;
            default:  nxt_st = READY;
        endcase
        issue   = nxt_st != READY && nxt_st != RESP;
        nxt_tms = (nxt_st == NAV_IN && (nxt_cnt == '0 || (op == OP_IR && nxt_cnt == LEN_W'(1)))) ||
                  (nxt_st == SHIFT && nxt_cnt == last) ||
                  (nxt_st == NAV_OUT && nxt_cnt == '0) ||
                  nxt_st == RST_SEQ;
    end

    always_ff @(posedge clk or posedge TRST)
        if (TRST) begin
            st        <= READY;
            cnt       <= '0;
            last      <= '0;
            op        <= OP_RESET;
            zero      <= 1'b0;
            dat       <= '0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            tck_en    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_tdo   <= '0;
        end else begin
            st        <= nxt_st;
            cnt       <= nxt_cnt;
            tck_en    <= issue;
            tms       <= issue ? nxt_tms : tms;
            tdi       <= nxt_st == SHIFT && dat[0];
            rsp_valid <= nxt_st == RESP;
            rsp_err   <= accept && cmd_op[1] && bad;
            if (accept) begin
                op      <= cmd_op;
                last    <= cmd_len - LEN_W'(1);
                zero    <= cmd_len == '0;
                dat     <= cmd_tdi;
                rsp_tdo <= '0;
            end else begin
                if (nxt_st == SHIFT) dat <= dat >> 1;
                if (tck_en && (tap_obs == SHIFT_DR || tap_obs == SHIFT_IR))
                    rsp_tdo <= rsp_tdo | (MAX_LEN'(tdo) << cnt);
            end
        end

endmodule

// File: tb/tb_tap_scan_sequencer.sv
// tb_tap_scan_sequencer: table vectors, hand sequences and random commands checked
// against a rule-level model and an emulated target TAP driving TDO.
module tb_tap_scan_sequencer;

    localparam logic [3:0] TLR = 4'hF, RTI = 4'hC, SDR = 4'h2, SIR = 4'hA, CDR = 4'h6, CIR = 4'hE;
    localparam logic [63:0] NX0 = 64'hCACCBABA62CE3232;
    localparam logic [63:0] NX1 = 64'hF97789DD417F0155;

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  len;
        logic [31:0] d;
        logic [31:0] p;
        int          tck;
        logic [31:0] tdo;
        logic        err;
        logic [3:0]  fin;
    } vec_t;

    logic        clk = 1'b0, TRST = 1'b0, cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [5:0]  cmd_len = 6'd0;
    logic [31:0] cmd_tdi = 32'd0;
    logic        tdo, cmd_ready, tms, tdi, tck_en, rsp_valid, rsp_err;
    logic [31:0] rsp_tdo;
    logic [3:0]  tap_obs;

    int          n_cmp = 0, n_bad = 0;
    logic        m_tlr = 1'b1;
    logic [31:0] tpat = 32'd0;
    logic [3:0]  tgt;
    logic [4:0]  sidx;
    logic [31:0] tcap;
    logic        in_shift;
    vec_t        tab[14];

    always #5 clk = ~clk;

    tap_scan_sequencer #(.MAX_LEN(32), .LEN_W(6)) dut (
        .clk(clk), .TRST(TRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_tdi(cmd_tdi),
        .tms(tms), .tdi(tdi), .tck_en(tck_en), .tdo(tdo),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_tdo(rsp_tdo), .tap_obs(tap_obs)
    );

    // emulated target: drives 1 on TDO outside shift so stray sampling shows up
    assign in_shift = tgt == SDR || tgt == SIR;
    assign tdo = in_shift ? tpat[sidx] : 1'b1;

    always @(posedge clk or posedge TRST)
        if (TRST) begin
            tgt  <= TLR;
            sidx <= '0;
            tcap <= '0;
        end else if (tck_en) begin
            if (tgt == CDR || tgt == CIR) begin sidx <= '0; tcap <= '0; end
            if (in_shift) begin tcap <= tcap | (32'(tdi) << sidx); sidx <= sidx + 5'd1; end
            tgt <= tms ? NX1[{tgt, 2'b00} +: 4] : NX0[{tgt, 2'b00} +: 4];
        end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic do_cmd(input vec_t v, input bit tabbed);
        logic bad, scan, pre, rerr, done;
        logic [127:0] ev, gv;
        logic [31:0] mask, etdo, rtdo;
        logic [3:0] eend, rend;
        int en, gn, k, rk, rdy_bad, tdi_bad;
        scan = v.op[1];
        bad  = scan && (v.len == 6'd0 || v.len > 6'd32);
        pre  = m_tlr && v.op != 2'd0 && !bad;
        mask = v.len >= 6'd32 ? 32'hFFFF_FFFF : (32'd1 << v.len) - 32'd1;
        ev = '0;
        en = 0;
        if (v.op == 2'd0) begin
            ev = 128'h1F;
            en = 5;
        end else if (!bad) begin
            if (pre) en = 1;
            if (v.op == 2'd1) en += int'(v.len);
            else begin
                ev |= 128'(1) << en; en++;
                if (v.op == 2'd2) begin ev |= 128'(1) << en; en++; end
                en += 2 + int'(v.len);
                ev |= 128'(1) << (en - 1);
                ev |= 128'(1) << en;
                en += 2;
            end
        end
        etdo = scan && !bad ? v.p & mask : 32'd0;
        eend = v.op == 2'd0 ? TLR : (bad && m_tlr) ? TLR : RTI;
        chk("ready_before", 128'(cmd_ready), 128'(1));
        cmd_op = v.op; cmd_len = v.len; cmd_tdi = v.d; tpat = v.p; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_tdi = $urandom; cmd_len = 6'($urandom);
        gv = '0; gn = 0; k = 1; rk = -1; rdy_bad = 0; tdi_bad = 0; done = 1'b0;
        rerr = 1'b0; rtdo = 32'd0; rend = 4'd0;
        while (!done && k <= 200) begin
            if (cmd_ready) rdy_bad++;
            if (tck_en) begin gv |= 128'(tms) << gn; gn++; end
            if (!(tck_en && in_shift) && tdi) tdi_bad++;
            if (rsp_valid) begin
                done = 1'b1; rk = k; rerr = rsp_err; rtdo = rsp_tdo; rend = tap_obs;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        chk("tck_count", 128'(gn), 128'(en));
        chk("tms_seq", gv, ev);
        chk("rsp_cycle", 128'(rk), 128'(en + 1));
        chk("rsp_err", 128'(rerr), 128'(bad));
        chk("rsp_tdo", 128'(rtdo), 128'(etdo));
        chk("end_state", 128'(rend), 128'(eend));
        chk("ready_busy", 128'(rdy_bad), 128'(0));
        chk("tdi_idle_zero", 128'(tdi_bad), 128'(0));
        if (scan && !bad) chk("tdi_shifted", 128'(tcap), 128'(v.d & mask));
        if (tabbed) begin
            chk("tab_tcks", 128'(gn), 128'(v.tck));
            chk("tab_tdo", 128'(rtdo), 128'(v.tdo));
            chk("tab_err", 128'(rerr), 128'(v.err));
            chk("tab_end", 128'(rend), 128'(v.fin));
        end
        @(negedge clk);
        chk("ready_after", 128'(cmd_ready), 128'(1));
        chk("single_pulse", 128'(rsp_valid), 128'(0));
        if (v.op == 2'd0) m_tlr = 1'b1;
        else if (!bad) m_tlr = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal;
    end

    initial begin
        vec_t v;
        vec_t bb[4];
        int k, pulses, issued, rsp_n, rdy_bad;
        logic loaded;
        tab[0]  = '{2'd3, 6'd8,  32'h000000A5, 32'h0000003C, 14, 32'h0000003C, 1'b0, RTI};
        tab[1]  = '{2'd2, 6'd4,  32'h00000009, 32'hFFFFFFF5, 10, 32'h00000005, 1'b0, RTI};
        tab[2]  = '{2'd0, 6'd0,  32'h0,        32'h0,         5, 32'h0,        1'b0, TLR};
        tab[3]  = '{2'd1, 6'd3,  32'h0,        32'h0,         4, 32'h0,        1'b0, RTI};
        tab[4]  = '{2'd3, 6'd0,  32'h000000A5, 32'h000000FF,  0, 32'h0,        1'b1, RTI};
        tab[5]  = '{2'd3, 6'd33, 32'hFFFFFFFF, 32'hFFFFFFFF,  0, 32'h0,        1'b1, RTI};
        tab[6]  = '{2'd1, 6'd0,  32'h0,        32'h0,         0, 32'h0,        1'b0, RTI};
        tab[7]  = '{2'd3, 6'd32, 32'hFFFF0001, 32'hDEADBEEF, 37, 32'hDEADBEEF, 1'b0, RTI};
        tab[8]  = '{2'd2, 6'd1,  32'h00000001, 32'h00000001,  7, 32'h00000001, 1'b0, RTI};
        tab[9]  = '{2'd1, 6'd40, 32'h0,        32'h0,        40, 32'h0,        1'b0, RTI};
        tab[10] = '{2'd0, 6'd0,  32'h0,        32'h0,         5, 32'h0,        1'b0, TLR};
        tab[11] = '{2'd2, 6'd0,  32'h00000003, 32'h00000003,  0, 32'h0,        1'b1, TLR};
        tab[12] = '{2'd1, 6'd0,  32'h0,        32'h0,         1, 32'h0,        1'b0, RTI};
        tab[13] = '{2'd2, 6'd32, 32'h12345678, 32'h80000001, 38, 32'h80000001, 1'b0, RTI};

        #1 TRST = 1'b1;
        @(negedge clk);
        chk("rst_tms", 128'(tms), 128'(1));
        chk("rst_tdi", 128'(tdi), 128'(0));
        chk("rst_tck_en", 128'(tck_en), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_err", 128'(rsp_err), 128'(0));
        chk("rst_rsp_tdo", 128'(rsp_tdo), 128'(0));
        chk("rst_tap", 128'(tap_obs), 128'(TLR));
        chk("rst_ready", 128'(cmd_ready), 128'(1));
        @(negedge clk);
        TRST = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) do_cmd(tab[i], 1'b1);

        // abort a DR scan at shift bit 5 of 16
        cmd_op = 2'd3; cmd_len = 6'd16; cmd_tdi = 32'h0000BEEF; tpat = 32'h1234ABCD; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!(in_shift && sidx == 5'd5) && k < 50) begin @(negedge clk); k++; end
        chk("trst_reach_bit5", 128'(k < 50), 128'(1));
        TRST = 1'b1;
        #1;
        chk("trst_tms", 128'(tms), 128'(1));
        chk("trst_tdi", 128'(tdi), 128'(0));
        chk("trst_tck_en", 128'(tck_en), 128'(0));
        chk("trst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("trst_rsp_tdo", 128'(rsp_tdo), 128'(0));
        chk("trst_tap", 128'(tap_obs), 128'(TLR));
        chk("trst_ready", 128'(cmd_ready), 128'(1));
        repeat (2) @(negedge clk);
        TRST = 1'b0;
        pulses = 0;
        repeat (20) begin @(negedge clk); pulses += int'(rsp_valid) + int'(tck_en); end
        chk("trst_no_rsp", 128'(pulses), 128'(0));
        m_tlr = 1'b1;
        do_cmd('{2'd3, 6'd16, 32'h0000BEEF, 32'h1234ABCD, 22, 32'h0000ABCD, 1'b0, RTI}, 1'b1);

        for (int i = 0; i < 60; i++) begin
            v.op = 2'($urandom_range(0, 3));
            if (v.op[1]) v.len = $urandom_range(0, 7) == 0 ? ($urandom_range(0, 1) == 0 ? 6'd0 : 6'($urandom_range(33, 63)))
                                                           : 6'($urandom_range(1, 32));
            else v.len = $urandom_range(0, 7) == 0 ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 12));
            v.d = $urandom; v.p = $urandom;
            v.tck = 0; v.tdo = 32'd0; v.err = 1'b0; v.fin = 4'd0;
            do_cmd(v, 1'b0);
        end

        // back-to-back with cmd_valid held high across commands
        bb[0] = '{2'd1, 6'd2, 32'h0, 32'h0, 0, 32'h0, 1'b0, RTI};
        bb[1] = '{2'd3, 6'd3, 32'h5, 32'h6, 0, 32'h0, 1'b0, RTI};
        bb[2] = '{2'd0, 6'd0, 32'h0, 32'h0, 0, 32'h0, 1'b0, TLR};
        bb[3] = '{2'd2, 6'd2, 32'h2, 32'h1, 0, 32'h0, 1'b0, RTI};
        issued = 0; rsp_n = 0; rdy_bad = 0; loaded = 1'b0;
        repeat (150) begin
            if (rsp_valid) rsp_n++;
            if (loaded && cmd_ready) rdy_bad++;
            loaded = 1'b0;
            if (cmd_ready) begin
                if (issued < 4) begin
                    cmd_op = bb[issued].op; cmd_len = bb[issued].len;
                    cmd_tdi = bb[issued].d; tpat = bb[issued].p;
                    cmd_valid = 1'b1; issued++; loaded = 1'b1;
                end else cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_issued", 128'(issued), 128'(4));
        chk("b2b_rsp_count", 128'(rsp_n), 128'(4));
        chk("b2b_ready_drop", 128'(rdy_bad), 128'(0));
        chk("b2b_end", 128'(tap_obs), 128'(RTI));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
